// File: rtl/alu_seq.sv
// Registered, handshaked integer ALU for the execute stage.
// Single-cycle ops complete in one cycle; MUL/MULHU/DIVU/REMU iterate for XLEN cycles.
module alu_seq #(
    parameter int XLEN      = 32,
    parameter int SHW       = $clog2(XLEN),
    parameter bit MULDIV_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in0,
    input  logic [XLEN-1:0] in1,
    input  logic [SHW-1:0]  shamt,
    input  logic [3:0]      op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out,
    output logic            iszero,
    output logic            busy
);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_SLL   = 4'b0100;
    localparam logic [3:0] OP_SRL   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLTU  = 4'b0111;
    localparam logic [3:0] OP_SRA   = 4'b1000;
    localparam logic [3:0] OP_SLT   = 4'b1001;
    localparam logic [3:0] OP_MUL   = 4'b1010;
    localparam logic [3:0] OP_MULHU = 4'b1011;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_DIVU  = 4'b1101;
    localparam logic [3:0] OP_REMU  = 4'b1110;

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_r, state_nxt_s;
    logic [XLEN-1:0] out_r;
    logic            iszero_r;
    logic [3:0]      op_r;
    logic [CW-1:0]   cnt_r;
    logic [XLEN-1:0] acc_r;    // product high half / partial remainder
    logic [XLEN-1:0] lo_r;     // product low half (multiplier) / quotient (dividend)
    logic [XLEN-1:0] b_r;      // multiplicand / divisor

    logic            accept_s;
    logic            is_muldiv_s;
    logic            is_div_r_s;
    logic [XLEN:0]   mul_sum_s;
    logic [XLEN:0]   div_diff_s;
    logic [XLEN-1:0] step_acc_s;
    logic [XLEN-1:0] step_lo_s;
    logic [XLEN-1:0] final_s;
    logic [XLEN-1:0] single_s;

    // Single-cycle result; iterative ops and reserved codes yield zero here.
    function automatic logic [XLEN-1:0] alu_fn(
        input logic [3:0]      f_op,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b,
        input logic [SHW-1:0]  sh
    );
        logic [XLEN-1:0] r;
        case (f_op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_ADD:  r = a + b;
            OP_XOR:  r = a ^ b;
            OP_SLL:  r = b << sh;
            OP_SRL:  r = b >> sh;
            OP_SUB:  r = a - b;
            OP_SLTU: r = {{(XLEN-1){1'b0}}, (a < b)};
            OP_SRA:  r = $signed(b) >>> sh;
            OP_SLT:  r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_NOR:  r = ~(a | b);
            default: r = {XLEN{1'b0}};
        endcase
        return r;
    endfunction

    assign in_ready  = (state_r == IDLE) || ((state_r == DONE) && out_ready);
    assign out_valid = (state_r == DONE);
    assign busy      = (state_r == BUSY);
    assign out       = out_r;
    assign iszero    = iszero_r;
    assign accept_s  = in_valid && in_ready;

    // Decode which ops take the iterative path.
    always_comb begin
        is_muldiv_s = 1'b0;
        if (MULDIV_EN == 1'b1) begin
            is_muldiv_s = (op == OP_MUL) || (op == OP_MULHU) ||
                          (op == OP_DIVU) || (op == OP_REMU);
        end else begin
            is_muldiv_s = 1'b0;
        end
    end

    assign single_s   = alu_fn(op, in0, in1, shamt);
    assign is_div_r_s = (op_r == OP_DIVU) || (op_r == OP_REMU);

    // One shift-add multiply step or one restoring-divide step.
    always_comb begin
        mul_sum_s  = {1'b0, acc_r} + (lo_r[0] ? {1'b0, b_r} : {(XLEN+1){1'b0}});
        div_diff_s = {acc_r, lo_r[XLEN-1]} - {1'b0, b_r};
        step_acc_s = {XLEN{1'b0}};
        step_lo_s  = {XLEN{1'b0}};
        if (is_div_r_s) begin
            if (!div_diff_s[XLEN]) begin
                step_acc_s = div_diff_s[XLEN-1:0];
                step_lo_s  = {lo_r[XLEN-2:0], 1'b1};
            end else begin
                step_acc_s = {acc_r[XLEN-2:0], lo_r[XLEN-1]};
                step_lo_s  = {lo_r[XLEN-2:0], 1'b0};
            end
        end else begin
            step_acc_s = mul_sum_s[XLEN:1];
            step_lo_s  = {mul_sum_s[0], lo_r[XLEN-1:1]};
        end
    end

    // Pick the result of the final iteration.
    always_comb begin
        case (op_r)
            OP_MUL:   final_s = step_lo_s;
            OP_MULHU: final_s = step_acc_s;
            OP_DIVU:  final_s = step_lo_s;
            OP_REMU:  final_s = step_acc_s;
            default:  final_s = {XLEN{1'b0}};
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = is_muldiv_s ? BUSY : DONE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            DONE: begin
                if (out_ready && in_valid) begin
                    state_nxt_s = is_muldiv_s ? BUSY : DONE;
                end else if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_r    <= {XLEN{1'b0}};
            iszero_r <= 1'b1;
            op_r     <= 4'b0000;
            cnt_r    <= {CW{1'b0}};
            acc_r    <= {XLEN{1'b0}};
            lo_r     <= {XLEN{1'b0}};
            b_r      <= {XLEN{1'b0}};
        end else if (accept_s) begin
            op_r  <= op;
            cnt_r <= {CW{1'b0}};
            acc_r <= {XLEN{1'b0}};
            if ((op == OP_DIVU) || (op == OP_REMU)) begin
                lo_r <= in0;
                b_r  <= in1;
            end else begin
                lo_r <= in1;
                b_r  <= in0;
            end
            if (!is_muldiv_s) begin
                out_r    <= single_s;
                iszero_r <= (single_s == {XLEN{1'b0}});
            end
        end else if (state_r == BUSY) begin
            acc_r <= step_acc_s;
            lo_r  <= step_lo_s;
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            if (cnt_r == CNT_LAST) begin
                out_r    <= final_s;
                iszero_r <= (final_s == {XLEN{1'b0}});
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: expected results are queued when an op is
// issued and popped when the ALU presents its result.
module tb_alu_seq;
    localparam int XLEN = 32;
    localparam int SHW  = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [XLEN-1:0] in0 = 32'h0;
    logic [XLEN-1:0] in1 = 32'h0;
    logic [SHW-1:0]  shamt = 5'd0;
    logic [3:0]      op = 4'd0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [XLEN-1:0] out;
    logic            iszero;
    logic            busy;

    int tests = 0;
    int fails = 0;
    logic [XLEN-1:0] exp_q[$];
    logic [XLEN-1:0] exp_v;

    always #5 clk = ~clk;

    alu_seq #(.XLEN(XLEN), .SHW(SHW), .MULDIV_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in0(in0), .in1(in1), .shamt(shamt), .op(op),
        .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .iszero(iszero), .busy(busy)
    );

    // Present an op at a falling edge, queue its result, return at the falling edge after acceptance.
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] s, input logic [31:0] e);
        bit ok = 1'b0;
        in_valid = 1'b1; op = o; in0 = a; in1 = b; shamt = s;
        exp_q.push_back(e);
        for (int n = 0; n < 100 && !ok; n++) begin
            #1;
            ok = in_ready;
            @(negedge clk);
        end
        in_valid = 1'b0;
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL accept_timeout: op %b got in_ready=0 for 100 cycles, required 1", o);
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) n = -1;
    endtask

    task automatic pop_exp();
        if (exp_q.size() > 0) exp_v = exp_q.pop_front();
        else exp_v = 32'hDEAD_BEEF;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tests++;
        if ({out_valid, busy, out, iszero, in_ready} !== {1'b0, 1'b0, 32'h0, 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL reset: got v=%b b=%b out=%h z=%b rdy=%b, required 0 0 0 1 1",
                     out_valid, busy, out, iszero, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        issue(4'b0010, 32'd5, 32'd7, 5'd0, 32'd12);
        pop_exp();
        tests++;
        if (out_valid !== 1'b1 || out !== exp_v || iszero !== 1'b0) begin
            fails++;
            $display("FAIL b2b_add: got v=%b out=%h z=%b, required 1 %h 0", out_valid, out, iszero, exp_v);
        end
        issue(4'b0110, 32'd3, 32'd5, 5'd0, 32'hFFFF_FFFE);
        pop_exp();
        tests++;
        if (out_valid !== 1'b1 || out !== exp_v || iszero !== 1'b0) begin
            fails++;
            $display("FAIL b2b_sub: got v=%b out=%h z=%b, required 1 %h 0", out_valid, out, iszero, exp_v);
        end
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_drain: got out_valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_single_ops();
        logic [3:0]  ops[10] = '{4'b1001, 4'b0111, 4'b1000, 4'b0100, 4'b0101,
                                 4'b0011, 4'b1100, 4'b0000, 4'b0001, 4'b1111};
        logic [31:0] as[10]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0,
                                 32'hFF00_FF00, 32'h0, 32'h0000_F0F0, 32'h0000_F0F0, 32'd5};
        logic [31:0] bs[10]  = '{32'd1, 32'd1, 32'h8000_0000, 32'd1, 32'h8000_0000,
                                 32'h0FF0_0FF0, 32'h0, 32'h0000_FF00, 32'h0000_FF00, 32'd6};
        logic [4:0]  ss[10]  = '{5'd0, 5'd0, 5'd4, 5'd31, 5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
        logic [31:0] es[10]  = '{32'd1, 32'd0, 32'hF800_0000, 32'h8000_0000, 32'd1,
                                 32'hF0F0_F0F0, 32'hFFFF_FFFF, 32'h0000_F000, 32'h0000_FFF0, 32'd0};
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            issue(ops[i], as[i], bs[i], ss[i], es[i]);
            pop_exp();
            tests++;
            if (out_valid !== 1'b1 || out !== exp_v || iszero !== (exp_v == 32'h0)) begin
                fails++;
                $display("FAIL single_op_%b: got v=%b out=%h z=%b, required 1 %h %b",
                         ops[i], out_valid, out, iszero, exp_v, (exp_v == 32'h0));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_mul();
        logic [3:0]  ops[4] = '{4'b1010, 4'b1011, 4'b1011, 4'b1010};
        logic [31:0] as[4]  = '{32'h0001_0000, 32'h0001_0000, 32'hFFFF_FFFF, 32'd12345};
        logic [31:0] bs[4]  = '{32'h0001_0000, 32'h0001_0000, 32'hFFFF_FFFF, 32'd6789};
        logic [31:0] es[4]  = '{32'h0, 32'd1, 32'hFFFF_FFFE, 32'd83810205};
        int n;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], as[i], bs[i], 5'd0, es[i]);
            tests++;
            if (in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0) begin
                fails++;
                $display("FAIL mul_busy: got rdy=%b busy=%b v=%b, required 0 1 0", in_ready, busy, out_valid);
            end
            wait_valid(n);
            // Visible XLEN falling edges after the accept edge, i.e. sampled at accept+33.
            tests++;
            if (n !== XLEN) begin
                fails++;
                $display("FAIL mul_latency: got %0d cycles, required %0d", n, XLEN);
            end
            pop_exp();
            tests++;
            if (out !== exp_v || iszero !== (exp_v == 32'h0) || busy !== 1'b0) begin
                fails++;
                $display("FAIL mul_result_%0d: got out=%h z=%b busy=%b, required %h %b 0",
                         i, out, iszero, busy, exp_v, (exp_v == 32'h0));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_div();
        logic [3:0]  ops[6] = '{4'b1101, 4'b1110, 4'b1101, 4'b1110, 4'b1101, 4'b1110};
        logic [31:0] as[6]  = '{32'd100, 32'd100, 32'd12345, 32'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] bs[6]  = '{32'd7, 32'd7, 32'd0, 32'd0, 32'd10, 32'd10};
        logic [31:0] es[6]  = '{32'd14, 32'd2, 32'hFFFF_FFFF, 32'd9, 32'h1999_9999, 32'd5};
        int n;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            issue(ops[i], as[i], bs[i], 5'd0, es[i]);
            wait_valid(n);
            pop_exp();
            tests++;
            if (n !== XLEN || out !== exp_v || iszero !== (exp_v == 32'h0)) begin
                fails++;
                $display("FAIL div_%0d: got cycles=%0d out=%h z=%b, required %0d %h %b",
                         i, n, out, iszero, XLEN, exp_v, (exp_v == 32'h0));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        issue(4'b0010, 32'd1, 32'd2, 5'd0, 32'd3);
        pop_exp();
        // A waiting op must be ignored while the result is stalled.
        in_valid = 1'b1; op = 4'b0011; in0 = 32'hAAAA_0000; in1 = 32'h0000_5555; shamt = 5'd0;
        exp_q.push_back(32'hAAAA_5555);
        for (int i = 0; i < 5; i++) begin
            tests++;
            if ({out_valid, in_ready, out, iszero} !== {1'b1, 1'b0, exp_v, 1'b0}) begin
                fails++;
                $display("FAIL bp_hold_%0d: got v=%b rdy=%b out=%h z=%b, required 1 0 %h 0",
                         i, out_valid, in_ready, out, iszero, exp_v);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_release: got in_ready=%b, required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        pop_exp();
        tests++;
        if (out_valid !== 1'b1 || out !== exp_v) begin
            fails++;
            $display("FAIL bp_next: got v=%b out=%h, required 1 %h", out_valid, out, exp_v);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        int n;
        out_ready = 1'b1;
        issue(4'b1101, 32'd1000, 32'd3, 5'd0, 32'd333);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        tests++;
        if ({out_valid, busy, out, iszero, in_ready} !== {1'b0, 1'b0, 32'h0, 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL mid_reset: got v=%b b=%b out=%h z=%b rdy=%b, required 0 0 0 1 1",
                     out_valid, busy, out, iszero, in_ready);
        end
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen = 1'b1;
            @(negedge clk);
        end
        tests++;
        if (seen) begin
            fails++;
            $display("FAIL mid_reset_discard: got a result after reset, required none");
        end
        issue(4'b0010, 32'd40, 32'd2, 5'd0, 32'd42);
        wait_valid(n);
        pop_exp();
        tests++;
        if (n !== 0 || out !== exp_v || iszero !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_add: got cycles=%0d out=%h z=%b, required 0 %h 0", n, out, iszero, exp_v);
        end
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_back_to_back();
        test_single_ops();
        test_mul();
        test_div();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
